// File: rtl/ptp_adj_sched_if.sv
// ptp_adj_sched_if
//   Bundles the request-side handshake (servo/CSR layer) and the PTP clock
//   adjustment bus used by ptp_adj_sched.
//   slave  : the scheduler (receives requests, drives clock commands)
//   master : the environment (servo layer + PTP clock instance)
//   Request side : req_offset, req_valid, req_ready, req_abort, busy, done
//   Clock side   : cur_ts_64, adj_active, ts_64_out, ts_64_valid,
//                  adj_ns, adj_fns, adj_count, adj_valid
interface ptp_adj_sched_if #(
    parameter int OFFSET_NS_WIDTH = 4
);
    logic [47:0]                req_offset;
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_abort;
    logic                       busy;
    logic                       done;
    logic [63:0]                cur_ts_64;
    logic                       adj_active;
    logic [63:0]                ts_64_out;
    logic                       ts_64_valid;
    logic [OFFSET_NS_WIDTH-1:0] adj_ns;
    logic [15:0]                adj_fns;
    logic [15:0]                adj_count;
    logic                       adj_valid;

    modport slave (
        input  req_offset, req_valid, req_abort, cur_ts_64, adj_active,
        output req_ready, busy, done, ts_64_out, ts_64_valid,
               adj_ns, adj_fns, adj_count, adj_valid
    );

    modport master (
        output req_offset, req_valid, req_abort, cur_ts_64, adj_active,
        input  req_ready, busy, done, ts_64_out, ts_64_valid,
               adj_ns, adj_fns, adj_count, adj_valid
    );
endinterface

// File: rtl/ptp_adj_sched.sv
// ptp_adj_sched
//   Turns one signed Q32.16 offset correction into PTP clock commands:
//   large offsets become a timestamp load (step), small ones a rate-limited
//   slew issued as saturated chunks plus one residual chunk.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : ptp_adj_sched_if.slave (request handshake + clock adjust bus)
//   All outputs are registered.
module ptp_adj_sched #(
    parameter int          OFFSET_NS_WIDTH = 4,
    parameter int          FNS_WIDTH       = 16,
    parameter int          SLEW_SHIFT      = 8,
    parameter logic [31:0] STEP_THRESH_NS  = 32'd1_000_000,
    parameter logic [63:0] LOAD_COMP       = 64'h0000_0000_0006_6666
) (
    input  logic                clk,
    input  logic                rst,
    ptp_adj_sched_if.slave      bus
);
    localparam int AW = OFFSET_NS_WIDTH + FNS_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_STEP, S_ISSUE, S_WAIT, S_RESID, S_RWAIT
    } state_t;

    state_t        state, state_n;
    logic          sign, sign_n;
    logic [46:0]   mag, mag_n;
    logic [1:0]    guard, guard_n;
    logic [63:0]   ts_r, ts_n;
    logic          tsv_r, tsv_n;
    logic [AW-1:0] adj_r, adj_n;
    logic [15:0]   cnt_r, cnt_n;
    logic          adjv_r, adjv_n;
    logic          done_r, done_n;
    logic          ready_r, ready_n;
    logic          busy_r, busy_n;

    logic [47:0]   abs_off;
    logic [46:0]   abs_mag;
    logic [46:0]   chunks;
    logic [15:0]   chunk_cnt;
    logic [46:0]   chunk_mag;
    logic [AW-1:0] slew_unit;
    logic [AW-1:0] mag_res;
    logic [63:0]   ts_sum;

    // |req_offset|; -2^47 has no positive 47-bit form and saturates
    assign abs_off   = bus.req_offset[47] ? (~bus.req_offset + 48'd1) : bus.req_offset;
    assign abs_mag   = abs_off[47] ? '1 : abs_off[46:0];
    assign chunks    = mag >> SLEW_SHIFT;
    assign chunk_cnt = (|chunks[46:16]) ? 16'hFFFF : chunks[15:0];
    assign chunk_mag = {31'd0, chunk_cnt} << SLEW_SHIFT;
    assign slew_unit = {{(AW-1){1'b0}}, 1'b1} << SLEW_SHIFT;
    assign mag_res   = mag[AW-1:0];
    // Step target is computed from the timestamp seen on the accept cycle so
    // the load is presented while the FSM sits in STEP.
    assign ts_sum    = bus.cur_ts_64 + {{16{bus.req_offset[47]}}, bus.req_offset} + LOAD_COMP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sign    <= 1'b0;
            mag     <= '0;
            guard   <= '0;
            ts_r    <= '0;
            tsv_r   <= 1'b0;
            adj_r   <= '0;
            cnt_r   <= '0;
            adjv_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_n;
            sign    <= sign_n;
            mag     <= mag_n;
            guard   <= guard_n;
            ts_r    <= ts_n;
            tsv_r   <= tsv_n;
            adj_r   <= adj_n;
            cnt_r   <= cnt_n;
            adjv_r  <= adjv_n;
            done_r  <= done_n;
            ready_r <= ready_n;
            busy_r  <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        sign_n  = sign;
        mag_n   = mag;
        guard_n = guard;
        ts_n    = ts_r;
        tsv_n   = 1'b0;
        adj_n   = adj_r;
        cnt_n   = cnt_r;
        adjv_n  = 1'b0;
        done_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.req_valid && ready_r) begin
                    sign_n = bus.req_offset[47];
                    mag_n  = abs_mag;
                    if ({1'b0, abs_mag[46:16]} >= STEP_THRESH_NS) begin
                        state_n = S_STEP;
                        ts_n    = ts_sum;
                        tsv_n   = 1'b1;
                    end else if (abs_mag == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = S_ISSUE;
                    end
                end
            end
            S_STEP: begin
                mag_n   = '0;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            S_ISSUE: begin
                if (chunk_cnt == 16'd0) begin
                    state_n = S_RESID;
                end else begin
                    adj_n   = sign ? -slew_unit : slew_unit;
                    cnt_n   = chunk_cnt;
                    adjv_n  = 1'b1;
                    mag_n   = mag - chunk_mag;
                    guard_n = 2'd2;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                // Guard lets the clock raise adj_active before it is trusted
                if (guard != 2'd0) begin
                    guard_n = guard - 2'd1;
                end else if (!bus.adj_active) begin
                    state_n = (mag >= (47'd1 << SLEW_SHIFT)) ? S_ISSUE : S_RESID;
                end
            end
            S_RESID: begin
                if (mag == '0) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    adj_n   = sign ? -mag_res : mag_res;
                    cnt_n   = 16'd1;
                    adjv_n  = 1'b1;
                    mag_n   = '0;
                    guard_n = 2'd2;
                    state_n = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (guard != 2'd0) begin
                    guard_n = guard - 2'd1;
                end else if (!bus.adj_active) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Zero-count command cancels whatever count the clock still holds
        if (bus.req_abort && (state inside {S_ISSUE, S_WAIT, S_RESID, S_RWAIT})) begin
            adj_n   = '0;
            cnt_n   = '0;
            adjv_n  = 1'b1;
            mag_n   = '0;
            guard_n = '0;
            done_n  = 1'b1;
            state_n = S_IDLE;
        end
    end

    assign ready_n = (state_n == S_IDLE);
    assign busy_n  = (state_n != S_IDLE);

    assign bus.req_ready   = ready_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.ts_64_out   = ts_r;
    assign bus.ts_64_valid = tsv_r;
    assign bus.adj_ns      = adj_r[AW-1:FNS_WIDTH];
    assign bus.adj_fns     = adj_r[FNS_WIDTH-1:0];
    assign bus.adj_count   = cnt_r;
    assign bus.adj_valid   = adjv_r;
endmodule

// File: doc/ptp_adj_sched.md
Name: ptp_adj_sched

Overview:
- Turns one signed time-offset correction request into the sequence of commands the PTP clock adjustment inputs accept.
- Offsets whose magnitude is at or above a threshold are applied as a hard 64-bit timestamp load (step).
- Smaller offsets are applied as a rate-limited slew. The slew is issued as saturated adjustment chunks plus one residual chunk, each chunk waiting for the clock's adjust-active flag to clear.
- Sits between the servo/CSR layer and the PTP clock instance.

Parameters:
- OFFSET_NS_WIDTH, 4, width of adj_ns to clock (matches clock instance)
- FNS_WIDTH, 16, fractional-ns width (this block supports 16 only)
- SLEW_SHIFT, 8, per-cycle slew magnitude = 2^SLEW_SHIFT fns (1/256 ns); must be < OFFSET_NS_WIDTH+FNS_WIDTH-1
- STEP_THRESH_NS, 32'd1_000_000, magnitude in ns at/above which a step is used
- LOAD_COMP, 64'h0000_0000_0006_6666, added to loaded ts_64 to cover the increment lost on the load cycle

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_offset  in  48  signed offset, Q32.16 (ns[47:16], fns[15:0])
- req_valid  in  1  request strobe
- req_ready  out  1  high in IDLE only
- req_abort  in  1  cancel slew in progress
- busy  out  1  high in any state but IDLE
- cur_ts_64  in  64  clock output_ts_64
- adj_active  in  1  clock input_adj_active
- ts_64_out  out  64  to clock input_ts_64
- ts_64_valid  out  1  to clock input_ts_64_valid
- adj_ns  out  OFFSET_NS_WIDTH  to clock input_adj_ns
- adj_fns  out  16  to clock input_adj_fns
- adj_count  out  16  to clock input_adj_count
- adj_valid  out  1  to clock input_adj_valid
- done  out  1  one-cycle pulse when a request completes or aborts

Behaviour:
- Reset (async, any state): go to IDLE; clear remaining-magnitude register and sign register.
- Output reset values: ts_64_out=0, ts_64_valid=0, adj_ns=0, adj_fns=0, adj_count=0, adj_valid=0, done=0, req_ready=1, busy=0.
- All outputs are registered.
- States: IDLE, STEP, ISSUE, WAIT, RESID, RWAIT.
- IDLE: on req_valid&&req_ready:
  - latch sign and mag = |req_offset| (47 bits; -2^47 saturates to 2^47-1).
  - if mag[46:16] >= STEP_THRESH_NS, go to STEP; else if mag==0, pulse done and stay in IDLE; else go to ISSUE.
- STEP: one cycle.
  - ts_64_out = cur_ts_64 + sign-extended req_offset + LOAD_COMP, modulo 2^64.
  - ts_64_valid=1 for exactly 1 cycle.
  - Then pulse done and return to IDLE.
- ISSUE:
  - c = min(mag>>SLEW_SHIFT, 65535).
  - If c==0, go to RESID.
  - Else drive {adj_ns,adj_fns} = sign ? -(2^SLEW_SHIFT) : +(2^SLEW_SHIFT), two's complement over OFFSET_NS_WIDTH+16 bits; adj_count=c; adj_valid=1 for 1 cycle.
  - mag -= c<<SLEW_SHIFT; go to WAIT.
- WAIT:
  - A 2-cycle guard counter runs first, so adj_active is not sampled before the clock has raised it.
  - Then, when adj_active==0: go to ISSUE if mag>=2^SLEW_SHIFT, else go to RESID.
- RESID:
  - If mag==0, pulse done and go to IDLE.
  - Else drive adj = ±mag (fits since mag<2^SLEW_SHIFT), adj_count=1, adj_valid=1; clear mag; go to RWAIT.
- RWAIT: same guard-then-wait as WAIT; then pulse done and go to IDLE.
- req_abort in ISSUE, WAIT, RESID or RWAIT:
  - Drive adj_valid=1 with adj_count=0 and adj=0; this kills any residual count in the clock.
  - Clear mag, pulse done, go to IDLE.
  - Abort has priority over that state's normal action in the same cycle.
  - Ignored in IDLE and STEP.
- req_valid while busy: ignored (req_ready=0); no queuing.
- adj_valid and ts_64_valid are never asserted in the same cycle.
- Latency from request to first command: 1 cycle (STEP or ISSUE entered on the cycle after acceptance).

Test Plan:
- Reset while in WAIT with adj_count=100 issued -> all outputs return to reset values immediately (async); req_ready=1.
- req_offset=48'h0000_0001_0000 (+1 ns) -> single adj_valid with adj=+0x0100, count=256; no residual; done after adj_active falls; ts_64_valid never asserted.
- req_offset=-48'h0000_0000_0180 -> chunk adj=-0x0100 (0xFFF00 for a 20-bit field) count=1, then residual adj=-0x0080 count=1, then done.
- req_offset=+512 ns (48'h0000_0200_0000) -> three chunks with counts 65535, 65535, 2, each +0x0100, each after adj_active clears; no residual.
- req_offset=+2,000,000 ns with cur_ts_64=64'h1000_0000 -> single ts_64_valid with ts_64_out=64'h1000_0000 + 64'h0000_1E84_8000_0000 + LOAD_COMP; no adj_valid; done next cycle.
- Abort asserted in WAIT of the 512 ns case -> adj_valid with count=0; done; IDLE; a following +1 ns request is accepted normally.
